// File: rtl/alu_engine_pkg.sv
// Shared encodings and types for the ALU execution unit.
// Contents: input-op / output-op encodings, opcode constants, flag bit
// indices, the result-queue entry payload and the multiplier state type.
package alu_engine_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 5;

    // Input-port operations (qualified by i_data_valid)
    typedef enum logic [1:0] {
        IN_LOAD_A = 2'd0,
        IN_LOAD_B = 2'd1,
        IN_EXEC   = 2'd2,
        IN_CLEAR  = 2'd3
    } in_op_e;

    // Read-out views of the queue head
    typedef enum logic [1:0] {
        OUT_LO    = 2'd0,
        OUT_HI    = 2'd1,
        OUT_FLAGS = 2'd2,
        OUT_COUNT = 2'd3
    } out_op_e;

    // Execute opcodes; 10..15 are illegal
    typedef enum logic [3:0] {
        OPC_ADD = 4'd0,
        OPC_SUB = 4'd1,
        OPC_AND = 4'd2,
        OPC_OR  = 4'd3,
        OPC_XOR = 4'd4,
        OPC_SHL = 4'd5,
        OPC_SHR = 4'd6,
        OPC_SAR = 4'd7,
        OPC_MUL = 4'd8,
        OPC_NOT = 4'd9
    } opcode_e;

    // Flag bit positions inside {E,V,C,N,Z}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_E = 4;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } result_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/alu_result_fifo.sv
// Result queue: DEPTH x {flags,hi,lo} synchronous FIFO.
// Ports: clk/rst_n (async active-low), push/pop/clear strobes, wdata in,
// head (current front entry), full/empty/count status.
// A push into a full queue is accepted only when a pop frees a slot the
// same cycle; clear has priority over push and pop.
module alu_result_fifo
    import alu_engine_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  result_entry_t           wdata,
    output result_entry_t           head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    result_entry_t     mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_engine.sv
// ALU execution unit behind the CPU's ALU special registers.
// Ports: i_clk, i_rst_n (async active-low); write side i_input_op,
// i_data_valid, i_data; read side i_output_op, i_result_empty (pop strobe);
// status o_result_valid, o_result (combinational head view), o_result_flags,
// o_busy (multiply in progress), o_drop (discarded-write pulse).
module alu_engine
    import alu_engine_pkg::*;
#(
    parameter int unsigned RESULT_DEPTH = 4,
    parameter int unsigned MUL_STEPS    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_input_op,
    input  logic        i_data_valid,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_output_op,
    input  logic        i_result_empty,
    output logic        o_result_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_result_flags,
    output logic        o_busy,
    output logic        o_drop
);

    localparam int unsigned CNT_W  = $clog2(RESULT_DEPTH) + 1;
    localparam int unsigned STEP_W = $clog2(MUL_STEPS) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);
    localparam logic [STEP_W-1:0] DONE_STEP = STEP_W'(MUL_STEPS);

    mul_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [63:0]       prod_q, prod_d, prod_step, mul_value;
    logic [31:0]       mcand_q, mcand_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              drop_q, drop_c;
    logic [32:0]       partial;
    logic [32:0]       sum;
    logic [63:0]       sh;
    result_entry_t     alu_entry, mul_entry, push_entry, head;
    logic              push_c, pop_c, clear_c, can_push;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    alu_result_fifo #(
        .DEPTH (RESULT_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .clear (clear_c),
        .wdata (push_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Single-cycle datapath on the registered operands
    always_comb begin
        alu_entry = '0;
        sum       = '0;
        sh        = '0;
        case (i_data[3:0])
            OPC_ADD: begin
                sum = {1'b0, a_q} + {1'b0, b_q};
                alu_entry.lo = sum[31:0];
                alu_entry.flags[FLAG_C] = sum[32];
                alu_entry.flags[FLAG_V] = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
            end
            OPC_SUB: begin
                sum = {1'b0, a_q} - {1'b0, b_q};
                alu_entry.lo = sum[31:0];
                alu_entry.flags[FLAG_C] = sum[32];
                alu_entry.flags[FLAG_V] = (a_q[31] != b_q[31]) && (sum[31] != a_q[31]);
            end
            OPC_AND: alu_entry.lo = a_q & b_q;
            OPC_OR:  alu_entry.lo = a_q | b_q;
            OPC_XOR: alu_entry.lo = a_q ^ b_q;
            OPC_NOT: alu_entry.lo = ~a_q;
            // Shifts run through a 64-bit window so the last bit out lands
            // next to the result and is 0 for a zero amount
            OPC_SHL: begin
                sh = {32'b0, a_q} << b_q[4:0];
                alu_entry.lo = sh[31:0];
                alu_entry.flags[FLAG_C] = sh[32];
            end
            OPC_SHR: begin
                sh = {a_q, 32'b0} >> b_q[4:0];
                alu_entry.lo = sh[63:32];
                alu_entry.flags[FLAG_C] = sh[31];
            end
            OPC_SAR: begin
                sh = 64'($signed({a_q, 32'b0}) >>> b_q[4:0]);
                alu_entry.lo = sh[63:32];
                alu_entry.flags[FLAG_C] = sh[31];
            end
            OPC_MUL: alu_entry = '0;
            default: alu_entry.flags[FLAG_E] = 1'b1;
        endcase
        alu_entry.flags[FLAG_Z] = (alu_entry.lo == '0);
        alu_entry.flags[FLAG_N] = alu_entry.lo[31];
    end

    // Shift-add step: {hi,lo} holds partial product over the remaining multiplier bits
    assign partial   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign prod_step = {partial, prod_q[31:1]};
    assign mul_value = (step_q == DONE_STEP) ? prod_q : prod_step;

    always_comb begin
        mul_entry       = '0;
        mul_entry.lo    = mul_value[31:0];
        mul_entry.hi    = mul_value[63:32];
        mul_entry.flags[FLAG_Z] = (mul_value == '0);
        mul_entry.flags[FLAG_N] = mul_value[63];
        mul_entry.flags[FLAG_C] = (mul_value[63:32] != '0);
        mul_entry.flags[FLAG_V] = (mul_value[63:32] != '0);
    end

    // Next-state: multiplier sequencing, write decode, queue control
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        a_d        = a_q;
        b_d        = b_q;
        drop_c     = 1'b0;
        push_c     = 1'b0;
        push_entry = '0;
        clear_c    = 1'b0;
        pop_c      = i_result_empty && !fifo_empty && (i_output_op == OUT_LO);
        can_push   = !fifo_full || pop_c;

        if (state_q == S_MUL) begin
            if (step_q != DONE_STEP) begin
                prod_d = prod_step;
                step_d = step_q + STEP_W'(1);
            end
            // Completion stalls (holding the product) until a slot is free
            if (step_q >= LAST_STEP && can_push) begin
                push_c     = 1'b1;
                push_entry = mul_entry;
                state_d    = S_IDLE;
            end
        end

        if (i_data_valid) begin
            case (i_input_op)
                IN_CLEAR: begin
                    clear_c = 1'b1;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = S_IDLE;
                    step_d  = '0;
                end
                IN_LOAD_A: begin
                    if (state_q == S_MUL) drop_c = 1'b1;
                    else                  a_d    = i_data;
                end
                IN_LOAD_B: begin
                    if (state_q == S_MUL) drop_c = 1'b1;
                    else                  b_d    = i_data;
                end
                default: begin
                    if (state_q == S_MUL || !can_push) begin
                        drop_c = 1'b1;
                    end else if (i_data[3:0] == OPC_MUL) begin
                        state_d = S_MUL;
                        step_d  = '0;
                        prod_d  = {32'b0, b_q};
                        mcand_d = a_q;
                    end else begin
                        push_c     = 1'b1;
                        push_entry = alu_entry;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            a_q     <= a_d;
            b_q     <= b_d;
            drop_q  <= drop_c;
        end
    end

    assign o_busy         = (state_q == S_MUL);
    assign o_drop         = drop_q;
    assign o_result_valid = !fifo_empty;

    // Combinational read-out of the head; everything but count reads 0 when empty
    always_comb begin
        o_result       = '0;
        o_result_flags = '0;
        if (!fifo_empty) o_result_flags = head.flags;
        case (i_output_op)
            OUT_LO:    if (!fifo_empty) o_result = head.lo;
            OUT_HI:    if (!fifo_empty) o_result = head.hi;
            OUT_FLAGS: if (!fifo_empty) o_result = 32'(head.flags);
            default:   o_result = 32'(fifo_count);
        endcase
    end

endmodule

// File: tb/tb_alu_engine.sv
// Self-checking bench for alu_engine: directed scenarios plus randomized
// traffic, all compared against a queue-based behavioural model.
module tb_alu_engine;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned STEPS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_input_op = 2'd0;
    logic        i_data_valid = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic [1:0]  i_output_op = 2'd0;
    logic        i_result_empty = 1'b0;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic [4:0]  o_result_flags;
    logic        o_busy;
    logic        o_drop;

    always #5 clk = ~clk;

    alu_engine #(
        .RESULT_DEPTH (DEPTH),
        .MUL_STEPS    (STEPS)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_input_op     (i_input_op),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .i_output_op    (i_output_op),
        .i_result_empty (i_result_empty),
        .o_result_valid (o_result_valid),
        .o_result       (o_result),
        .o_result_flags (o_result_flags),
        .o_busy         (o_busy),
        .o_drop         (o_drop)
    );

    // Behavioural model state: queue of {flags,hi,lo}
    logic [68:0] mq[$];
    logic [31:0] ma = 32'd0;
    logic [31:0] mb = 32'd0;
    logic [68:0] mul_res = 69'd0;
    int          busy_left = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total = 0;
    int          busy_cycles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Expected entry from the arithmetic definition of each opcode
    function automatic logic [68:0] ref_exec(input int opc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        c, v;
        longint      s;
        int          n;
        n = int'(b[4:0]);
        c = 1'b0; v = 1'b0; r = 32'd0; p = 64'd0; s = 0;
        case (opc)
            0: begin
                p = 64'(a) + 64'(b); r = p[31:0]; c = p[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                r = a - b; c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << n; c = (n == 0) ? 1'b0 : a[32-n]; end
            6: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            7: begin r = 32'($signed(a) >>> n); c = (n == 0) ? 1'b0 : a[n-1]; end
            8: begin
                p = 64'(a) * 64'(b);
                return {1'b0, (p[63:32] != 0), (p[63:32] != 0), p[63], (p == 0), p};
            end
            9: r = ~a;
            default: return {5'b10001, 64'd0};
        endcase
        return {1'b0, v, c, r[31], (r == 0), 32'd0, r};
    endfunction

    task automatic check_head();
        logic [68:0] e;
        e = (mq.size() > 0) ? mq[0] : 69'd0;
        i_output_op = 2'd0; #1 chk("rd_lo", o_result, e[31:0]);
        i_output_op = 2'd1; #1 chk("rd_hi", o_result, e[63:32]);
        i_output_op = 2'd2; #1 chk("rd_flags", o_result, {27'd0, e[68:64]});
        i_output_op = 2'd3; #1 chk("rd_count", o_result, 32'(mq.size()));
        chk("valid", 32'(o_result_valid), 32'(mq.size() > 0));
        chk("flags", 32'(o_result_flags), 32'(e[68:64]));
    endtask

    // One clock: optional write, optional pop; model updated alongside
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] data, input logic pop_req);
        logic        busy, do_pop, exp_drop, exec_push, mul_start;
        logic [68:0] exec_e;
        busy      = (busy_left > 0);
        do_pop    = pop_req && (mq.size() > 0);
        exp_drop  = 1'b0;
        exec_push = 1'b0;
        mul_start = 1'b0;
        exec_e    = 69'd0;
        if (v && op == 2'd2) begin
            if (busy || (mq.size() == DEPTH && !do_pop)) exp_drop = 1'b1;
            else if (data[3:0] == 4'd8) mul_start = 1'b1;
            else begin exec_push = 1'b1; exec_e = ref_exec(int'(data[3:0]), ma, mb); end
        end else if (v && op != 2'd3 && busy) begin
            exp_drop = 1'b1;
        end

        i_data_valid   = v;
        i_input_op     = op;
        i_data         = data;
        i_output_op    = pop_req ? 2'd0 : 2'd2;
        i_result_empty = 1'b1;
        @(posedge clk);

        if (v && op == 2'd3) begin
            mq.delete(); ma = 32'd0; mb = 32'd0; busy_left = 0;
        end else begin
            if (do_pop) mq.delete(0);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) mq.push_back(mul_res);
            end
            if (exec_push) mq.push_back(exec_e);
            if (mul_start) begin mul_res = ref_exec(8, ma, mb); busy_left = STEPS; end
            if (v && op == 2'd0 && !busy) ma = data;
            if (v && op == 2'd1 && !busy) mb = data;
        end

        #1;
        i_data_valid   = 1'b0;
        i_result_empty = 1'b0;
        chk("drop", 32'(o_drop), 32'(exp_drop));
        chk("busy", 32'(o_busy), 32'(busy_left > 0));
        check_head();
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] rdata;
        int          r;

        // Reset values
        #7;
        i_output_op = 2'd0; #1 chk("rst_lo", o_result, 32'd0);
        i_output_op = 2'd3; #1 chk("rst_count", o_result, 32'd0);
        chk("rst_valid", 32'(o_result_valid), 32'd0);
        chk("rst_flags", 32'(o_result_flags), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry-out to zero
        step(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 2'd1, 32'd1, 1'b0);
        step(1'b1, 2'd2, 32'd0, 1'b0);
        chk("add_flags", 32'(o_result_flags), 32'h05);
        step(1'b0, 2'd0, 32'd0, 1'b1);

        // SUB overflow, then SAR
        step(1'b1, 2'd0, 32'h8000_0000, 1'b0);
        step(1'b1, 2'd2, 32'd1, 1'b0);
        i_output_op = 2'd0; #1 chk("sub_lo", o_result, 32'h7FFF_FFFF);
        chk("sub_flags", 32'(o_result_flags), 32'h08);
        step(1'b0, 2'd0, 32'd0, 1'b1);
        step(1'b1, 2'd1, 32'd4, 1'b0);
        step(1'b1, 2'd2, 32'd7, 1'b0);
        i_output_op = 2'd0; #1 chk("sar_lo", o_result, 32'hF800_0000);
        chk("sar_flags", 32'(o_result_flags), 32'h02);
        step(1'b0, 2'd0, 32'd0, 1'b1);

        // Multiply: busy window, drop of a load while busy
        step(1'b1, 2'd0, 32'h0001_0000, 1'b0);
        step(1'b1, 2'd1, 32'h0001_0000, 1'b0);
        step(1'b1, 2'd2, 32'd8, 1'b0);
        busy_cycles = o_busy ? 1 : 0;
        step(1'b1, 2'd0, 32'h1234_5678, 1'b0);
        chk("busy_load_drop", 32'(o_drop), 32'd1);
        if (o_busy) busy_cycles++;
        for (int i = 0; i < 100 && o_busy; i++) begin
            step(1'b0, 2'd0, 32'd0, 1'b0);
            if (o_busy) busy_cycles++;
        end
        chk("mul_busy_cycles", 32'(busy_cycles), 32'd32);
        i_output_op = 2'd1; #1 chk("mul_hi", o_result, 32'd1);
        chk("mul_flags", 32'(o_result_flags), 32'h0C);
        step(1'b0, 2'd0, 32'd0, 1'b1);
        step(1'b1, 2'd2, 32'd0, 1'b0);   // A must still be 0x10000
        step(1'b1, 2'd3, 32'd0, 1'b0);

        // Queue full: drop, then accepted with same-cycle pop
        step(1'b1, 2'd0, 32'd1, 1'b0);
        step(1'b1, 2'd1, 32'd2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 32'd0, 1'b0);
        step(1'b1, 2'd2, 32'd0, 1'b0);
        chk("full_drop", 32'(o_drop), 32'd1);
        step(1'b1, 2'd2, 32'd1, 1'b1);
        i_output_op = 2'd3; #1 chk("full_pop_count", o_result, 32'd4);
        step(1'b1, 2'd3, 32'd0, 1'b0);

        // Illegal opcode; non-zero output op with strobe must not pop
        step(1'b1, 2'd2, 32'd12, 1'b0);
        chk("illegal_flags", 32'(o_result_flags), 32'h11);
        step(1'b0, 2'd0, 32'd0, 1'b0);
        i_output_op = 2'd3; #1 chk("no_pop_count", o_result, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r     = int'($urandom_range(0, 19));
            rdata = $urandom;
            rop   = (r < 5) ? 2'd0 : (r < 9) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            if (rop == 2'd2 && rdata[3:0] == 4'd8 && $urandom_range(0, 3) != 0) rdata[3:0] = 4'd0;
            step(($urandom_range(0, 7) != 0), rop, rdata, ($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of a multiply with two entries queued
        step(1'b1, 2'd3, 32'd0, 1'b0);
        step(1'b1, 2'd0, 32'd3, 1'b0);
        step(1'b1, 2'd1, 32'd5, 1'b0);
        step(1'b1, 2'd2, 32'd0, 1'b0);
        step(1'b1, 2'd2, 32'd1, 1'b0);
        step(1'b1, 2'd2, 32'd8, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        mq.delete(); ma = 32'd0; mb = 32'd0; busy_left = 0;
        i_output_op = 2'd0; #1 chk("mid_rst_lo", o_result, 32'd0);
        i_output_op = 2'd3; #1 chk("mid_rst_count", o_result, 32'd0);
        chk("mid_rst_valid", 32'(o_result_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_flags", 32'(o_result_flags), 32'd0);
        chk("mid_rst_drop", 32'(o_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'd0, 1'b0);

        // Clear wins over a same-cycle pop
        step(1'b1, 2'd2, 32'd0, 1'b0);
        step(1'b1, 2'd2, 32'd3, 1'b0);
        step(1'b1, 2'd3, 32'd0, 1'b1);
        i_output_op = 2'd3; #1 chk("clear_pop_count", o_result, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/alu_engine.md
Name: alu_engine

Overview:
- Execution unit behind the CPU's ALU special registers.
- The CPU writes operands and commands through an input-op/data-valid port and reads results combinationally through an output-op port the same cycle.
- Single-cycle ops take effect on the next edge; unsigned 32x32 multiply is iterative.
- Results and flags are buffered in a small result queue so the CPU can issue several operations before reading back.

Parameters:
- RESULT_DEPTH, 4: result queue entries; power of two, >=2.
- MUL_STEPS, 32: multiply iterations; fixed at 32 for the 32-bit datapath.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_input_op  in  2  0 load A, 1 load B, 2 execute (opcode = i_data[3:0]), 3 clear.
- i_data_valid  in  1  qualifies i_input_op/i_data this cycle.
- i_data  in  32  operand or opcode.
- i_output_op  in  2  0 result low word, 1 result high word, 2 flags zero-extended, 3 queue count.
- i_result_empty  in  1  read strobe; pops the head only when i_output_op==0.
- o_result_valid  out  1  queue non-empty.
- o_result  out  32  combinational view selected by i_output_op.
- o_result_flags  out  5  head flags {E,V,C,N,Z} (bit4..0).
- o_busy  out  1  multiply in progress.
- o_drop  out  1  one-cycle pulse: an accepted write was discarded.

Behaviour:
- Reset (async, while i_rst_n low):
  - A=B=0, queue empty, multiplier idle.
  - o_result_valid=0, o_result=0, o_result_flags=0, o_busy=0, o_drop=0.
  - Reset mid-multiply aborts it; no result is queued.
- Input write: i_data_valid=1, one op per cycle.
  - Load A/B: register updates next edge.
  - Execute: uses A/B as registered before this edge.
  - Clear:
    - empties the queue, aborts any multiply, zeroes A and B;
    - wins over a same-cycle pop;
    - accepted while busy.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR, 7 SAR (amount B[4:0]).
  - 8 MUL (unsigned, 64-bit), 9 NOT A.
  - 10-15 illegal.
- Single-cycle ops: entry {lo=result, hi=0, flags} enqueued on the edge after the execute write (latency 1).
- Flags:
  - Z = result==0; N = result[31].
  - ADD: C = carry-out, V = signed overflow.
  - SUB: C = borrow (A<B unsigned), V = signed overflow.
  - Logic/NOT: C=V=0.
  - Shifts: C = last bit shifted out (0 when amount 0), V=0.
  - MUL: Z on all 64 bits zero, N = bit63, C=V = (hi!=0).
  - E=1 only for illegal opcodes; those enqueue lo=hi=0, flags=10001b.
- MUL:
  - Shift-add, one step per cycle.
  - o_busy rises the edge after the execute write and stays high exactly MUL_STEPS cycles.
  - Entry enqueued on the edge o_busy falls (result visible MUL_STEPS+1 edges after the write).
- While busy:
  - load/execute writes are discarded and o_drop pulses;
  - pops of already-queued entries still work.
- Queue full:
  - execute is discarded with o_drop, unless a pop occurs the same cycle (pop frees the slot first).
  - A multiply completing into a full queue stalls with o_busy held until a slot frees.
- Pop:
  - i_result_empty & o_result_valid & i_output_op==0 advances the head next edge.
  - Pop on empty is ignored (no drop pulse).
- Simultaneous push and pop: both happen; count unchanged.
- Read-out (combinational from head, from the current i_output_op): op 0 lo, 1 hi, 2 {27'b0,flags}, 3 count. All read 0 when empty, except count.
- Pointer wrap modulo RESULT_DEPTH; count width log2(RESULT_DEPTH)+1.

Decomposition:
- Shared header alu_engine_defs.vh (shared with cpu for decode):
  - input-op and output-op encodings;
  - opcode constants;
  - flag bit indices.
- Sub-module alu_result_fifo: RESULT_DEPTH x 69-bit {flags,hi,lo} synchronous FIFO with async reset, push/pop/clear, full/empty/count.
- Iterative multiplier and single-cycle datapath stay in alu_engine.

Test Plan:
- Load A=0xFFFFFFFF, B=1, execute ADD -> next cycle o_result_valid=1, op0 reads 0, flags Z=1 C=1 V=0.
- Load A=0x80000000, B=1, execute SUB -> lo=0x7FFFFFFF, V=1, C=0; then execute SAR with B=4 on A=0x80000000 -> lo=0xF8000000, N=1.
- Execute MUL A=0x10000, B=0x10000 -> o_busy high 32 cycles, then op0=0, op1=1, C=V=1, Z=0. A load during busy -> o_drop pulse, A unchanged.
- Fill queue with 4 ADDs, 5th execute -> o_drop; 5th execute with simultaneous op0 pop -> accepted, count stays 4.
- Execute opcode 12 -> flags 10001b, lo=hi=0. Reading op2 with i_result_empty=1 -> no pop.
- Assert i_rst_n=0 mid-multiply with 2 entries queued -> all outputs 0 immediately. After release, clear op with pop same cycle -> queue empty, count 0.
